// File: rtl/iscore_audio_pkg.sv
// Shared audio definitions: default sample width, mixer FSM encoding and
// saturation bounds for the default sample width.
package iscore_audio_pkg;

    localparam int unsigned SAMPLE_W_DEF = 16;

    // Signed clamp limits for a SAMPLE_W_DEF-bit sample.
    localparam int SAT_MAX = (2 ** (SAMPLE_W_DEF - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (SAMPLE_W_DEF - 1));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        COLLECT = 2'd2,
        OUT     = 2'd3
    } mix_state_e;

endpackage

// File: rtl/mix_saturate.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits (IN_W >= OUT_W).
// Ports:
//   din_i   signed IN_W  value to clamp
//   dout_c  signed OUT_W clamped value in [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module mix_saturate #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_c
);

    // Bounds expressed at the input width so the comparison is full-precision.
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    always_comb begin
        dout_c = OUT_W'(din_i);
        if (din_i > MAX_V) begin
            dout_c = OUT_W'(MAX_V);
        end else if (din_i < MIN_V) begin
            dout_c = OUT_W'(MIN_V);
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Mixes NUM_VOICES signed voice samples into one saturated codec sample.
// A codec request broadcasts generate_next_sample, the enabled voices are
// collected (with a timeout), and the clamped sum is presented with a
// one-cycle mix_valid strobe.
// Configuration: define VOICE_MIXER_ATTEN_EN to add mix_shift[1:0], an
// arithmetic right shift applied to the sum before saturation.
// Ports:
//   clk, reset (async, active-low)
//   codec_sample_req      in   request pulse (ignored while busy)
//   voice_enable          in   per-voice enable, latched on request
//   mix_shift             in   attenuation shift (VOICE_MIXER_ATTEN_EN only)
//   generate_next_sample  out  one-cycle broadcast to voices
//   voice_sample_ready    in   per-voice sample strobe
//   voice_samples         in   packed signed voice samples
//   mix_sample_out        out  saturated mix, held until next mix_valid
//   mix_valid             out  one-cycle strobe with new mix
//   busy                  out  high outside IDLE
//   timeout_err           out  sticky missed-deadline flag, cleared by reset
module voice_mixer
    import iscore_audio_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           codec_sample_req,
    input  logic [NUM_VOICES-1:0]          voice_enable,
`ifdef VOICE_MIXER_ATTEN_EN
    input  logic [1:0]                     mix_shift,
`endif
    output logic                           generate_next_sample,
    input  logic [NUM_VOICES-1:0]          voice_sample_ready,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    output logic signed [SAMPLE_W-1:0]     mix_sample_out,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int unsigned ACC_W = SAMPLE_W + $clog2(NUM_VOICES + 1);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    mix_state_e                  state_q, state_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic [NUM_VOICES-1:0]       pending_q, pending_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        terr_q, terr_d;
    logic                        gen_q, valid_q, busy_q;
    logic signed [SAMPLE_W-1:0]  mix_q;
    logic signed [ACC_W-1:0]     mix_src;
    logic signed [SAMPLE_W-1:0]  sat_c;

    // Next-state, accumulator, pending mask and timeout counter.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        case (state_q)
            IDLE: begin
                if (codec_sample_req) begin
                    pending_d = voice_enable;
                    acc_d     = '0;
                    state_d   = (voice_enable == '0) ? OUT : REQ;
                end
            end
            REQ: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = COLLECT;
            end
            COLLECT: begin
                for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                    if (voice_sample_ready[i] && pending_q[i]) begin
                        acc_d        = acc_d + ACC_W'($signed(voice_samples[i*SAMPLE_W +: SAMPLE_W]));
                        pending_d[i] = 1'b0;
                    end
                end
                // A voice arriving in the final cycle still counts as on time.
                if (pending_d == '0) begin
                    state_d = OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    terr_d    = 1'b1;
                    pending_d = '0;
                    state_d   = OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef VOICE_MIXER_ATTEN_EN
    assign mix_src = acc_d >>> mix_shift;
`else
    assign mix_src = acc_d;
`endif

    mix_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (SAMPLE_W)
    ) u_sat (
        .din_i  (mix_src),
        .dout_c (sat_c)
    );

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
            gen_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            mix_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
            gen_q     <= (state_d == REQ);
            valid_q   <= (state_d == OUT);
            busy_q    <= (state_d != IDLE);
            if (state_d == OUT) begin
                mix_q <= sat_c;
            end
        end
    end

    assign generate_next_sample = gen_q;
    assign mix_valid            = valid_q;
    assign busy                 = busy_q;
    assign timeout_err          = terr_q;
    assign mix_sample_out       = mix_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: expected mixes are queued by the stimulus
// and popped by a monitor on every mix_valid.
module tb_voice_mixer;

    localparam int unsigned NV = 3;
    localparam int unsigned SW = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  codec_sample_req = 1'b0;
    logic [NV-1:0]         voice_enable = '0;
    logic                  generate_next_sample;
    logic [NV-1:0]         voice_sample_ready = '0;
    logic [NV*SW-1:0]      voice_samples = '0;
    logic signed [SW-1:0]  mix_sample_out;
    logic                  mix_valid;
    logic                  busy;
    logic                  timeout_err;
`ifdef VOICE_MIXER_ATTEN_EN
    logic [1:0]            mix_shift = 2'd0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int gen_cnt  = 0;
    int valid_cnt = 0;
    logic signed [SW-1:0] exp_q[$];

    voice_mixer #(
        .NUM_VOICES (NV),
        .SAMPLE_W   (SW),
        .TIMEOUT    (255)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .codec_sample_req     (codec_sample_req),
        .voice_enable         (voice_enable),
`ifdef VOICE_MIXER_ATTEN_EN
        .mix_shift            (mix_shift),
`endif
        .generate_next_sample (generate_next_sample),
        .voice_sample_ready   (voice_sample_ready),
        .voice_samples        (voice_samples),
        .mix_sample_out       (mix_sample_out),
        .mix_valid            (mix_valid),
        .busy                 (busy),
        .timeout_err          (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every mix_valid; count broadcast pulses.
    always @(negedge clk) begin
        if (generate_next_sample) gen_cnt++;
        if (mix_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_mix_valid", 1, 0);
            end else begin
                check("mix_sample", longint'(mix_sample_out), longint'(exp_q.pop_front()));
            end
        end
    end

    // Issue a request at a falling edge; return at the start of COLLECT
    // (or at cycle 1 when nothing is enabled).
    task automatic start_req(input logic [NV-1:0] en);
        @(negedge clk);
        voice_enable     = en;
        codec_sample_req = 1'b1;
        @(negedge clk);
        codec_sample_req = 1'b0;
        if (en != '0) begin
            check("gen_at_cycle1", longint'(generate_next_sample), 1);
            @(negedge clk);
        end else begin
            check("gen_none_when_disabled", longint'(generate_next_sample), 0);
            check("valid_at_cycle1", longint'(mix_valid), 1);
        end
    endtask

    // Present samples on the voices in mask for one cycle.
    task automatic present(input logic [NV-1:0] mask, input int v0, input int v1, input int v2);
        voice_samples[0*SW +: SW] = SW'(v0);
        voice_samples[1*SW +: SW] = SW'(v1);
        voice_samples[2*SW +: SW] = SW'(v2);
        voice_sample_ready = mask;
        @(negedge clk);
        voice_sample_ready = '0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_bound", longint'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    int g0, v0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mix_sample", longint'(mix_sample_out), 0);
        check("rst_mix_valid", longint'(mix_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_timeout_err", longint'(timeout_err), 0);
        check("rst_gen", longint'(generate_next_sample), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: voices on separate cycles, 100 - 40 + 7 = 67
        g0 = gen_cnt; v0 = valid_cnt;
        exp_q.push_back(16'sd67);
        start_req(3'b111);
        check("t1_busy", longint'(busy), 1);
        present(3'b001, 100, 0, 0);
        present(3'b010, 0, -40, 0);
        check("t1_no_early_valid", longint'(mix_valid), 0);
        present(3'b100, 0, 0, 7);
        check("t1_valid_after_last", longint'(mix_valid), 1);
        wait_idle(20);
        check("t1_gen_pulses", gen_cnt - g0, 1);
        check("t1_valid_pulses", valid_cnt - v0, 1);

        // 2: simultaneous voices, positive and negative saturation
        exp_q.push_back(16'(iscore_audio_pkg::SAT_MAX));
        start_req(3'b111);
        present(3'b111, 20000, 20000, 20000);
        wait_idle(20);
        exp_q.push_back(16'(iscore_audio_pkg::SAT_MIN));
        start_req(3'b111);
        present(3'b111, -20000, -20000, -20000);
        wait_idle(20);

        // 3: nothing enabled
        g0 = gen_cnt;
        exp_q.push_back(16'sd0);
        start_req(3'b000);
        wait_idle(20);
        check("t3_gen_pulses", gen_cnt - g0, 0);

        // 4: voice 1 never answers
        exp_q.push_back(16'sd500);
        start_req(3'b011);
        present(3'b001, 500, 0, 0);
        repeat (200) @(negedge clk);
        check("t4_still_waiting", longint'(busy), 1);
        check("t4_no_err_yet", longint'(timeout_err), 0);
        wait_idle(200);
        check("t4_timeout_err", longint'(timeout_err), 1);
        exp_q.push_back(16'sd5);
        start_req(3'b001);
        present(3'b001, 5, 0, 0);
        wait_idle(20);
        check("t4_err_sticky", longint'(timeout_err), 1);

        // 5: request and enable change mid-COLLECT are ignored; stale ready ignored
        g0 = gen_cnt; v0 = valid_cnt;
        exp_q.push_back(16'sd60);
        start_req(3'b111);
        present(3'b001, 10, 0, 0);
        codec_sample_req = 1'b1;
        voice_enable     = 3'b000;
        present(3'b010, 0, 20, 0);
        codec_sample_req = 1'b0;
        present(3'b001, 999, 0, 0);
        present(3'b100, 0, 0, 30);
        wait_idle(20);
        check("t5_gen_pulses", gen_cnt - g0, 1);
        check("t5_valid_pulses", valid_cnt - v0, 1);

        // 5b: reset mid-COLLECT, then a clean mix
        start_req(3'b111);
        present(3'b001, 1234, 0, 0);
        reset = 1'b0;
        #1;
        check("t5_rst_busy", longint'(busy), 0);
        check("t5_rst_timeout_err", longint'(timeout_err), 0);
        check("t5_rst_mix_sample", longint'(mix_sample_out), 0);
        check("t5_rst_mix_valid", longint'(mix_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'sd6);
        start_req(3'b111);
        present(3'b111, 1, 2, 3);
        wait_idle(20);

`ifdef VOICE_MIXER_ATTEN_EN
        // 6: 3000 >>> 2 = 750
        mix_shift = 2'd2;
        exp_q.push_back(16'sd750);
        start_req(3'b111);
        present(3'b111, 1000, 1000, 1000);
        wait_idle(20);
        mix_shift = 2'd0;
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
